// File: rtl/fwd_hazard_ctrl.sv
// Purpose: operand-forward selects and load-use stall control for the 5-stage core (macro FWD_HAZARD_FORWARD_EN enables forwarding).
// Latency: fwd_sel_a/b are registered at the ID->EX edge; stall is combinational from the slots and ID inputs.
// Backpressure: stall holds PC and IF/ID and injects a bubble into EX; without forwarding, stall persists until the producer reaches WB.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  localparam logic [1:0]       SEL_RF  = 2'd0;
  localparam logic [1:0]       SEL_MEM = 2'd1;
  localparam logic [1:0]       SEL_WB  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam slot_t            BUBBLE  = '0;

  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t id_slot;

  // True when slot s will write register r; x0 is hardwired and never a hazard.
  function automatic logic writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  logic hit_ex_a;
  logic hit_ex_b;
  logic hit_mem_a;
  logic hit_mem_b;

  // Per-operand producer matches against the EX and MEM occupants.
  always_comb begin
    hit_ex_a  = id_use_rs1 && writes(ex_q,  id_rs1);
    hit_ex_b  = id_use_rs2 && writes(ex_q,  id_rs2);
    hit_mem_a = id_use_rs1 && writes(mem_q, id_rs1);
    hit_mem_b = id_use_rs2 && writes(mem_q, id_rs2);
  end

  assign id_slot = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

`ifdef FWD_HAZARD_FORWARD_EN
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    stall = id_valid && ex_q.mem_read && (hit_ex_a || hit_ex_b);
  end

  // Youngest producer wins: MEM-stage ALU result beats WB-stage data.
  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (hit_ex_a && !ex_q.mem_read) sel_a_d = SEL_MEM;
    else if (hit_mem_a)             sel_a_d = SEL_WB;
    if (hit_ex_b && !ex_q.mem_read) sel_b_d = SEL_MEM;
    else if (hit_mem_b)             sel_b_d = SEL_WB;
  end

  // Register selects at the ID->EX boundary; bubbles always read the register file.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else if (stall || !id_valid) begin
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else begin
      fwd_sel_a <= sel_a_d;
      fwd_sel_b <= sel_b_d;
    end
  end
`else
  // No bypass paths: wait until every producer of a used source has reached WB.
  always_comb begin
    stall = id_valid && (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
  end

  assign fwd_sel_a = SEL_RF;
  assign fwd_sel_b = SEL_RF;
`endif

  // Advance the tracking slots; a stalled or empty ID stage enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (stall || !id_valid) ? BUBBLE : id_slot;
    end
  end

  // Saturating stall-cycle counter for performance analysis.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // The WB occupant and the load flag past EX are kept for debug visibility only;
  // the write-through register file already exposes WB data to ID.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, mem_q.mem_read, ex_q.mem_read};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed instruction table, reset/saturation sequences, random traffic vs. a history model.
// Runs in whichever configuration FWD_HAZARD_FORWARD_EN selects; expectations follow that configuration.
// Stalled instructions are re-presented by the bench acting as upstream.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr;
  } instr_t;

  typedef struct {
    instr_t i;
    int st_f; int sa; int sb;   // forwarding build: stall cycles, sel_a, sel_b after issue
    int st_n;                   // non-forwarding build: stall cycles (selects always 0)
  } row_t;

  int checks = 0;
  int failures = 0;

  instr_t cur;
  instr_t hist[$];   // issued instructions, most recent first: [0] in EX, [1] in MEM
  int     m_cnt;
  int     m_sa;
  int     m_sb;

  function automatic instr_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr);
    instr_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic row_t rw_(instr_t i, int st_f, int sa, int sb, int st_n);
    row_t r;
    r.i = i; r.st_f = st_f; r.sa = sa; r.sb = sb; r.st_n = st_n;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    hist.delete();
    hist.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    hist.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    m_cnt = 0; m_sa = 0; m_sb = 0;
  endtask

  // Distance to the youngest in-flight producer of r: 1 = EX, 2 = MEM, 0 = none.
  function automatic int youngest(int r);
    if (r == 0) return 0;
    for (int d = 0; d < 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd == r) return d + 1;
    return 0;
  endfunction

  function automatic bit m_stall(instr_t i);
    int da, db;
    da = i.u1 ? youngest(i.rs1) : 0;
    db = i.u2 ? youngest(i.rs2) : 0;
    if (!i.v) return 1'b0;
`ifdef FWD_HAZARD_FORWARD_EN
    return (da == 1 || db == 1) && hist[0].mr;
`else
    return (da != 0) || (db != 0);
`endif
  endfunction

  function automatic int m_sel(bit u, int r);
`ifdef FWD_HAZARD_FORWARD_EN
    if (!u) return 0;
    return youngest(r);
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    bit s;
    if (!arst_n) begin
      model_reset();
      return;
    end
    s = m_stall(cur);
    if (s && m_cnt < CNT_SAT) m_cnt++;
    if (s || !cur.v) begin
      m_sa = 0; m_sb = 0;
      hist.push_front(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      m_sa = m_sel(cur.u1, cur.rs1);
      m_sb = m_sel(cur.u2, cur.rs2);
      hist.push_front(cur);
    end
    void'(hist.pop_back());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(instr_t i);
    cur          = i;
    id_valid     = i.v;
    id_rs1       = i.rs1[AW-1:0];
    id_rs2       = i.rs2[AW-1:0];
    id_use_rs1   = i.u1;
    id_use_rs2   = i.u2;
    id_rd        = i.rd[AW-1:0];
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
  endtask

  // One clock with inputs already driven (entered and left at a falling edge).
  task automatic cycle(output bit st);
    #1;
    st = stall;
    chk("model_stall", {31'b0, stall}, {31'b0, m_stall(cur)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_sel_a", {30'b0, fwd_sel_a}, m_sa);
    chk("model_sel_b", {30'b0, fwd_sel_b}, m_sb);
    chk("model_cnt", {24'b0, stall_cnt}, m_cnt);
  endtask

  // Present an instruction and hold it while stalled; returns the number of stall cycles.
  task automatic issue(instr_t i, output int nst);
    bit st;
    drive(i);
    nst = 0;
    do begin
      cycle(st);
      if (st) nst++;
    end while (st && nst < 8);
    if (st) begin
      failures++;
      $display("FAIL stall_timeout actual=%0d required=<8", nst);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t   tbl[$];
    instr_t bub;
    int     nst, es, ea, eb, ecnt, total;
    bit     st;

    bub = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // ---- reset state ----
    arst_n = 1'b0;
    drive(bub);
    model_reset();
    @(negedge clk);
    cycle(st);
    cycle(st);
    #1;
    chk("reset_stall", {31'b0, stall}, 0);
    chk("reset_sel_a", {30'b0, fwd_sel_a}, 0);
    chk("reset_sel_b", {30'b0, fwd_sel_b}, 0);
    chk("reset_cnt", {24'b0, stall_cnt}, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // ---- directed table: instruction, fwd {stalls, sel_a, sel_b}, no-fwd stalls ----
    tbl.push_back(rw_(mk(1, 2, 3, 1, 1, 1, 1, 0), 0, 0, 0, 0));  // add x1,x2,x3
    tbl.push_back(rw_(mk(1, 1, 3, 1, 1, 2, 1, 0), 0, 1, 0, 2));  // add x2,x1,x3 (distance 1)
    tbl.push_back(rw_(mk(0, 2, 2, 1, 1, 0, 0, 0), 0, 0, 0, 0));  // invalid ID with matching sources
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 0, 0, 1, 1, 1, 1, 0), 0, 0, 0, 0));  // add x1,x0,x0
    tbl.push_back(rw_(mk(1, 7, 8, 1, 1, 1, 1, 0), 0, 0, 0, 0));  // add x1,x7,x8
    tbl.push_back(rw_(mk(1, 1, 1, 1, 1, 4, 1, 0), 0, 1, 1, 2));  // sub x4,x1,x1 (youngest wins)
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 0, 0, 1, 1, 1, 1, 0), 0, 0, 0, 0));  // add x1
    tbl.push_back(rw_(mk(1, 10, 11, 1, 1, 9, 1, 0), 0, 0, 0, 0)); // add x9,x10,x11
    tbl.push_back(rw_(mk(1, 1, 1, 1, 1, 4, 1, 0), 0, 2, 2, 1));  // sub x4,x1,x1 (distance 2)
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 6, 0, 1, 0, 5, 1, 1), 0, 0, 0, 0));  // lw x5,0(x6)
    tbl.push_back(rw_(mk(1, 5, 0, 1, 1, 6, 1, 0), 1, 2, 0, 2));  // add x6,x5,x0 (load-use)
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 6, 0, 1, 0, 0, 1, 1), 0, 0, 0, 0));  // lw x0,0(x6)
    tbl.push_back(rw_(mk(1, 0, 0, 1, 1, 6, 1, 0), 0, 0, 0, 0));  // add x6,x0,x0
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 1, 0, 1, 1, 7, 1, 0), 0, 0, 0, 0));  // add x7,x1,x0
    tbl.push_back(rw_(mk(1, 3, 7, 1, 0, 8, 1, 0), 0, 0, 0, 0));  // rs2=x7 not used
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 0, 0, 0, 0, 7, 1, 1), 0, 0, 0, 0));  // lw x7
    tbl.push_back(rw_(mk(1, 2, 7, 1, 0, 9, 1, 0), 0, 0, 0, 0));  // rs2=x7 not used after load
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(bub, 0, 0, 0, 0));
    tbl.push_back(rw_(mk(1, 2, 0, 1, 1, 1, 0, 0), 0, 0, 0, 0));  // store: rd field x1, no write
    tbl.push_back(rw_(mk(1, 1, 1, 1, 1, 3, 1, 0), 0, 0, 0, 0));  // add x3,x1,x1
    tbl.push_back(rw_(mk(1, 0, 3, 1, 1, 10, 1, 0), 0, 0, 1, 2)); // add x10,x0,x3 (operand b)

    ecnt = 0;
    foreach (tbl[k]) begin
      issue(tbl[k].i, nst);
`ifdef FWD_HAZARD_FORWARD_EN
      es = tbl[k].st_f; ea = tbl[k].sa; eb = tbl[k].sb;
`else
      es = tbl[k].st_n; ea = 0; eb = 0;
`endif
      ecnt += es;
      chk($sformatf("row%0d_stalls", k), nst, es);
      chk($sformatf("row%0d_sel_a", k), {30'b0, fwd_sel_a}, ea);
      chk($sformatf("row%0d_sel_b", k), {30'b0, fwd_sel_b}, eb);
      chk($sformatf("row%0d_cnt", k), {24'b0, stall_cnt}, ecnt);
    end

    // ---- reset asserted during a load-use stall ----
    for (int k = 0; k < 3; k++) issue(bub, nst);
    issue(mk(1, 6, 0, 1, 0, 5, 1, 1), nst);
    drive(mk(1, 5, 0, 1, 1, 6, 1, 0));
    #1;
    chk("rst_mid_stall_before", {31'b0, stall}, 1);
    arst_n = 1'b0;
    cycle(st);
    #1;
    chk("rst_mid_stall_after", {31'b0, stall}, 0);
    chk("rst_mid_sel_a", {30'b0, fwd_sel_a}, 0);
    chk("rst_mid_sel_b", {30'b0, fwd_sel_b}, 0);
    chk("rst_mid_cnt", {24'b0, stall_cnt}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    issue(cur, nst);
    chk("rst_mid_fresh_stalls", nst, 0);

    // ---- saturation: chain of dependent loads until the counter overflows its range ----
    arst_n = 1'b0;
    cycle(st);
    arst_n = 1'b1;
    total = 0;
    for (int k = 0; k < 400 && total < CNT_SAT + 20; k++) begin
      issue(mk(1, 5, 0, 1, 0, 5, 1, 1), nst);
      total += nst;
    end
    chk("sat_reached", (total > CNT_SAT) ? 1 : 0, 1);
    chk("sat_cnt", {24'b0, stall_cnt}, CNT_SAT);
    issue(mk(1, 5, 0, 1, 0, 5, 1, 1), nst);
    chk("sat_hold", {24'b0, stall_cnt}, CNT_SAT);

    // ---- randomized traffic against the model ----
    arst_n = 1'b0;
    drive(bub);
    cycle(st);
    arst_n = 1'b1;
    st = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!st) begin
        drive(mk(($urandom_range(0, 9) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0)));
      end
      arst_n = ($urandom_range(0, 99) != 0);
      cycle(st);
      if (!arst_n) st = 1'b0;
    end
    arst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
